// File: rtl/bus_pkg.sv
// Shared encodings for the two-master/two-slave serial bus:
// response codes, read/write strobe values and the slave FSM states.
package bus_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY  = 2'b00;
  localparam resp_t RESP_ERROR = 2'b01;
  localparam resp_t RESP_SPLIT = 2'b11;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_RDATA,
    S_RESP
  } slave_state_t;

endpackage

// File: rtl/serial_slave_port_if.sv
// Controller-to-slave serial bus bundle.
// master = bus controller side, slave = serial_slave_port side.
interface serial_slave_port_if;
  import bus_pkg::*;

  logic  sel;
  logic  read_write;
  logic  a_valid;
  logic  a_in;
  logic  d_valid;
  logic  d_in;
  logic  d_out;
  logic  d_out_valid;
  logic  ready;
  resp_t response;
  logic  split;

  modport master (
    output sel, read_write,
    output a_valid, a_in,
    output d_valid, d_in,
    input  d_out, d_out_valid,
    input  ready, response, split
  );

  modport slave (
    input  sel, read_write,
    input  a_valid, a_in,
    input  d_valid, d_in,
    output d_out, d_out_valid,
    output ready, response, split
  );

endinterface

// File: rtl/slave_mem.sv
// Single-port synchronous RAM, one-cycle read latency.
// Contents are not reset.
module slave_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: deserialises address/write data, serialises reads.
// Optional feature: SERIAL_SLAVE_SPLIT_EN signals split/11 during read wait states.
module serial_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  serial_slave_port_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(ADDR_W + DATA_W + WAIT_CYCLES + 2);

`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  slave_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] dsh_q;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rd_m;
  logic              rw_q;
  logic              ready_q;
  logic              split_q;
  logic              dout_q;
  logic              dval_q;
  resp_t             resp_q;
  logic              in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;

  assign in_range = {{(32-ADDR_W){1'b0}}, addr_q} < 32'(MEM_DEPTH);
  assign rd_m     = in_range ? rdata : '0;

  // Present the completing address on the last address bit so the
  // read is already under way in the first wait cycle.
  assign mem_idx = (state == S_ADDR)
                 ? {addr_q[IDX_W-2:0], bus.a_in}
                 : addr_q[IDX_W-1:0];

  assign mem_we = rst && (state == S_RESP)
               && (rw_q == RW_WRITE) && in_range;

  slave_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dsh_q   <= '0;
      rw_q    <= 1'b0;
      ready_q <= 1'b1;
      split_q <= 1'b0;
      dout_q  <= 1'b0;
      dval_q  <= 1'b0;
      resp_q  <= RESP_OKAY;
    end else begin
      unique case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (bus.sel && bus.a_valid) begin
            addr_q <= {addr_q[ADDR_W-2:0], bus.a_in};
            rw_q   <= bus.read_write;
            cnt    <= CNT_W'(1);
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!bus.sel) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (bus.a_valid) begin
            addr_q <= {addr_q[ADDR_W-2:0], bus.a_in};
            if (cnt == CNT_W'(ADDR_W - 1)) begin
              if (rw_q == RW_WRITE) begin
                cnt   <= '0;
                state <= S_WDATA;
              end else begin
                cnt     <= CNT_W'(1);
                ready_q <= 1'b0;
                split_q <= SPLIT_EN;
                resp_q  <= SPLIT_EN ? RESP_SPLIT : RESP_OKAY;
                state   <= S_WAIT;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (!bus.sel) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (bus.d_valid) begin
            wdata_q <= {wdata_q[DATA_W-2:0], bus.d_in};
            if (cnt == CNT_W'(DATA_W - 1)) begin
              cnt    <= '0;
              resp_q <= in_range ? RESP_OKAY : RESP_ERROR;
              state  <= S_RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!bus.sel) begin
            cnt     <= '0;
            ready_q <= 1'b1;
            split_q <= 1'b0;
            resp_q  <= RESP_OKAY;
            state   <= S_IDLE;
          end else if (cnt == CNT_W'(WAIT_CYCLES)) begin
            cnt     <= CNT_W'(1);
            ready_q <= 1'b1;
            split_q <= 1'b0;
            resp_q  <= RESP_OKAY;
            dval_q  <= 1'b1;
            dout_q  <= rd_m[DATA_W-1];
            dsh_q   <= {rd_m[DATA_W-2:0], 1'b0};
            state   <= S_RDATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RDATA: begin
          if (cnt == CNT_W'(DATA_W)) begin
            cnt    <= '0;
            dval_q <= 1'b0;
            dout_q <= 1'b0;
            resp_q <= in_range ? RESP_OKAY : RESP_ERROR;
            state  <= S_RESP;
          end else begin
            cnt    <= cnt + 1'b1;
            dout_q <= dsh_q[DATA_W-1];
            dsh_q  <= {dsh_q[DATA_W-2:0], 1'b0};
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          resp_q  <= RESP_OKAY;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.d_out       = dout_q;
  assign bus.d_out_valid = dval_q;
  assign bus.ready       = ready_q;
  assign bus.response    = resp_q;
  assign bus.split       = split_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Randomised self-checking bench for serial_slave_port against a
// transaction-level memory model.
module tb_serial_slave_port;
  import bus_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 128;
  localparam int WC    = 2;

`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam int SPLIT_EXP = WC;
`else
  localparam int SPLIT_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_slave_port_if bus();

  serial_slave_port #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MEM_DEPTH   (DEPTH),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mem_m [256];
  bit            known [256];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.a_valid = 1'b0;
    bus.d_valid = 1'b0;
    bus.a_in    = 1'b0;
    bus.d_in    = 1'b0;
  endtask

  task automatic send_addr(input logic [AW-1:0] a,
                           input logic rw,
                           input int stall_at,
                           input int stall_len,
                           input bit rnd);
    for (int i = 0; i < AW; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          @(negedge clk);
          bus.sel = 1'b1;
          idle_in();
        end
      end
      if (rnd && i > 0 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        idle_in();
      end
      @(negedge clk);
      bus.sel        = 1'b1;
      bus.read_write = rw;
      bus.d_valid    = 1'b0;
      bus.a_valid    = 1'b1;
      bus.a_in       = a[AW-1-i];
    end
  endtask

  task automatic send_data(input logic [DW-1:0] d,
                           input int nbits,
                           input bit rnd);
    for (int i = 0; i < nbits; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        idle_in();
      end
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.d_valid = 1'b1;
      bus.d_in    = d[DW-1-i];
    end
  endtask

  task automatic wr(input logic [AW-1:0] a,
                    input logic [DW-1:0] d,
                    input int stall_at,
                    input int stall_len,
                    input bit rnd);
    send_addr(a, RW_WRITE, stall_at, stall_len, rnd);
    send_data(d, DW, rnd);
    @(negedge clk);
    idle_in();
    chk("wr_ready", 32'(bus.ready), 1);
    chk("wr_resp", 32'(bus.response),
        32'((a < DEPTH) ? RESP_OKAY : RESP_ERROR));
    if (a < DEPTH) begin
      mem_m[a] = d;
      known[a] = 1'b1;
    end
    @(negedge clk);
    chk("wr_resp_end", 32'(bus.response), 32'(RESP_OKAY));
  endtask

  task automatic wr_abort(input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          input int nbits);
    send_addr(a, RW_WRITE, -1, 0, 1'b0);
    send_data(d, nbits, 1'b0);
    @(negedge clk);
    bus.sel = 1'b0;
    idle_in();
    repeat (3) begin
      @(negedge clk);
      chk("abort_resp", 32'(bus.response), 32'(RESP_OKAY));
      chk("abort_ready", 32'(bus.ready), 1);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a,
                    input int rst_at,
                    input bit rnd);
    int waits = 0;
    int rlow  = 0;
    int sp    = 0;
    int r11   = 0;
    int nb    = 0;
    int dlow  = 0;
    int guard = 0;
    logic [DW-1:0] got = '0;
    logic [DW-1:0] exp;
    exp = (a < DEPTH) ? mem_m[a] : '0;
    send_addr(a, RW_READ, -1, 0, rnd);
    @(negedge clk);
    idle_in();
    while (!bus.d_out_valid && guard < 40) begin
      waits++;
      if (!bus.ready) rlow++;
      if (bus.split) sp++;
      if (bus.response == RESP_SPLIT) r11++;
      @(negedge clk);
      guard++;
    end
    chk("rd_timeout", 32'(guard < 40), 1);
    chk("rd_wait", waits, WC);
    chk("rd_ready_low", rlow, WC);
    chk("rd_split", sp, SPLIT_EXP);
    chk("rd_resp11", r11, SPLIT_EXP);
    while (bus.d_out_valid && nb < DW + 4) begin
      if (!bus.ready || bus.split) dlow++;
      got = {got[DW-2:0], bus.d_out};
      nb++;
      if (nb == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dval", 32'(bus.d_out_valid), 0);
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_resp", 32'(bus.response), 32'(RESP_OKAY));
        chk("rst_dout", 32'(bus.d_out), 0);
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    chk("rd_nbits", nb, DW);
    chk("rd_data", 32'(got), 32'(exp));
    chk("rd_data_phase", dlow, 0);
    chk("rd_resp", 32'(bus.response),
        32'((a < DEPTH) ? RESP_OKAY : RESP_ERROR));
    chk("rd_resp_ready", 32'(bus.ready), 1);
    @(negedge clk);
    chk("rd_resp_end", 32'(bus.response), 32'(RESP_OKAY));
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bus.sel        = 1'b0;
    bus.read_write = RW_READ;
    idle_in();
    repeat (3) @(negedge clk);
    chk("rst_state_ready", 32'(bus.ready), 1);
    chk("rst_state_resp", 32'(bus.response), 32'(RESP_OKAY));
    chk("rst_state_split", 32'(bus.split), 0);
    chk("rst_state_dval", 32'(bus.d_out_valid), 0);
    chk("rst_state_dout", 32'(bus.d_out), 0);
    rst = 1'b1;
    @(negedge clk);

    wr(8'h10, 8'hA5, -1, 0, 1'b0);
    rd(8'h10, -1, 1'b0);

    wr(8'h90, 8'h11, -1, 0, 1'b0);
    rd(8'h90, -1, 1'b0);
    rd(8'h10, -1, 1'b0);

    wr(8'h05, 8'h3C, 4, 3, 1'b0);
    rd(8'h05, -1, 1'b0);

    wr(8'h20, 8'h77, -1, 0, 1'b0);
    wr_abort(8'h20, 8'hFF, 3);
    rd(8'h20, -1, 1'b0);
    wr_abort(8'h90, 8'h00, 3);

    rd(8'h10, 3, 1'b0);
    @(negedge clk);
    rd(8'h10, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.sel     = 1'b0;
        bus.a_valid = 1'($urandom_range(0, 1));
        bus.a_in    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0)
        a = 8'($urandom_range(128, 255));
      else
        a = 8'($urandom_range(0, 127));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0 && (a >= DEPTH || known[a]))
        rd(a, -1, 1'b1);
      else
        wr(a, d, -1, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
